// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports plus the RAM-side bus of the arbiter.
interface ram_arbiter_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 32
);
    logic                     p0_req;
    logic [3:0]               p0_we;
    logic [ADDRESS_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0]    p0_data;
    logic                     p0_gnt;
    logic                     p0_rvalid;
    logic [DATA_WIDTH-1:0]    p0_q;
    logic                     p1_req;
    logic [3:0]               p1_we;
    logic [ADDRESS_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0]    p1_data;
    logic                     p1_gnt;
    logic                     p1_rvalid;
    logic [DATA_WIDTH-1:0]    p1_q;
    logic [3:0]               ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_data;
    logic [DATA_WIDTH-1:0]    ram_q;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_data, p1_req, p1_we, p1_addr, p1_data, ram_q,
        output p0_gnt, p0_rvalid, p0_q, p1_gnt, p1_rvalid, p1_q, ram_we, ram_addr, ram_data
    );
    modport master (
        output p0_req, p0_we, p0_addr, p0_data, p1_req, p1_we, p1_addr, p1_data, ram_q,
        input  p0_gnt, p0_rvalid, p0_q, p1_gnt, p1_rvalid, p1_q, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port byte-enabled RAM between two requesters.
module ram_arbiter #(
    parameter int ADDRESS_WIDTH  = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    logic                     r_last;
    logic                     r_pend;
    logic                     r_tag;
    logic                     w_g0;
    logic                     w_g1;
    logic                     w_rv0;
    logic                     w_rv1;
    logic [3:0]               w_we;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_data;

    // r_last=1 means port 1 was served last, so port 0 wins the next tie
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst_n) begin
            if (bus.p0_req && bus.p1_req) begin
                w_g0 = (FIXED_PRIORITY != 0) || r_last;
                w_g1 = !w_g0;
            end else begin
                w_g0 = bus.p0_req;
                w_g1 = bus.p1_req;
            end
        end
    end

    always_comb begin
        w_we   = w_g1 ? bus.p1_we   : w_g0 ? bus.p0_we   : '0;
        w_addr = w_g1 ? bus.p1_addr : w_g0 ? bus.p0_addr : '0;
        w_data = w_g1 ? bus.p1_data : w_g0 ? bus.p0_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
            r_pend <= 1'b0;
            r_tag  <= 1'b0;
        end else begin
            r_pend <= w_g0 || w_g1;
            if (w_g0 || w_g1) begin
                r_tag  <= w_g1;
                r_last <= w_g1;
            end
        end
    end

    // rst_n gates the response so a reset arriving right after a grant drops it
    assign w_rv0 = r_pend && !r_tag && rst_n;
    assign w_rv1 = r_pend && r_tag && rst_n;

    assign bus.p0_gnt    = w_g0;
    assign bus.p1_gnt    = w_g1;
    assign bus.p0_rvalid = w_rv0;
    assign bus.p1_rvalid = w_rv1;
    assign bus.p0_q      = w_rv0 ? bus.ram_q : '0;
    assign bus.p1_q      = w_rv1 ? bus.ram_q : '0;
    assign bus.ram_we    = w_we;
    assign bus.ram_addr  = w_addr;
    assign bus.ram_data  = w_data;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: round-robin and fixed-priority arbiters, each against its own RAM
// and a transaction-level reference (grant rule, shadow memory, one-cycle response).
module tb_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    ram_arbiter_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) bus0 ();
    ram_arbiter_if #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32)) bus1 ();

    ram_arbiter #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    ram_arbiter #(.ADDRESS_WIDTH(14), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // index [k][p]: k=0 round-robin instance, k=1 fixed-priority instance
    logic        req[2][2];
    logic [3:0]  we[2][2];
    logic [13:0] addr[2][2];
    logic [31:0] wd[2][2];
    logic        gnt[2][2];
    logic        rv[2][2];
    logic [31:0] q[2][2];
    logic [3:0]  rwe[2];
    logic [13:0] raddr[2];
    logic [31:0] rdata[2];
    logic [31:0] rq[2];

    assign bus0.p0_req = req[0][0];  assign bus0.p1_req = req[0][1];
    assign bus0.p0_we = we[0][0];    assign bus0.p1_we = we[0][1];
    assign bus0.p0_addr = addr[0][0]; assign bus0.p1_addr = addr[0][1];
    assign bus0.p0_data = wd[0][0];  assign bus0.p1_data = wd[0][1];
    assign bus0.ram_q = rq[0];
    assign bus1.p0_req = req[1][0];  assign bus1.p1_req = req[1][1];
    assign bus1.p0_we = we[1][0];    assign bus1.p1_we = we[1][1];
    assign bus1.p0_addr = addr[1][0]; assign bus1.p1_addr = addr[1][1];
    assign bus1.p0_data = wd[1][0];  assign bus1.p1_data = wd[1][1];
    assign bus1.ram_q = rq[1];
    assign gnt[0][0] = bus0.p0_gnt;  assign gnt[0][1] = bus0.p1_gnt;
    assign rv[0][0] = bus0.p0_rvalid; assign rv[0][1] = bus0.p1_rvalid;
    assign q[0][0] = bus0.p0_q;      assign q[0][1] = bus0.p1_q;
    assign rwe[0] = bus0.ram_we;     assign raddr[0] = bus0.ram_addr;
    assign rdata[0] = bus0.ram_data;
    assign gnt[1][0] = bus1.p0_gnt;  assign gnt[1][1] = bus1.p1_gnt;
    assign rv[1][0] = bus1.p0_rvalid; assign rv[1][1] = bus1.p1_rvalid;
    assign q[1][0] = bus1.p0_q;      assign q[1][1] = bus1.p1_q;
    assign rwe[1] = bus1.ram_we;     assign raddr[1] = bus1.ram_addr;
    assign rdata[1] = bus1.ram_data;

    logic [31:0] ram_mem[2][16384];
    logic [31:0] shadow[2][16384];
    logic        m_last[2];
    logic        m_pend[2];
    logic        m_tag[2];
    logic [31:0] m_exp[2];
    logic        m_gl[2][2];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // winner from the arbitration rules: -1 none, else port number
    function automatic int win(input int k);
        if (!rst_n) return -1;
        if (req[k][0] && req[k][1]) return (k == 1) ? 0 : (m_last[k] ? 0 : 1);
        if (req[k][0]) return 0;
        if (req[k][1]) return 1;
        return -1;
    endfunction

    // RAM (fed by the DUT) and the reference model advance together on each edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rq[k] <= ram_mem[k][raddr[k]];
            for (int b = 0; b < 4; b++)
                if (rwe[k][b]) ram_mem[k][raddr[k]][8*b +: 8] <= rdata[k][8*b +: 8];
            m_gl[k][0] <= win(k) == 0;
            m_gl[k][1] <= win(k) == 1;
            if (!rst_n) begin
                m_last[k] <= 1'b1;
                m_pend[k] <= 1'b0;
                m_tag[k]  <= 1'b0;
            end else begin
                m_pend[k] <= win(k) >= 0;
                if (win(k) >= 0) begin
                    m_tag[k]  <= win(k) == 1;
                    m_last[k] <= win(k) == 1;
                    m_exp[k]  <= shadow[k][addr[k][win(k)]];
                    for (int b = 0; b < 4; b++)
                        if (we[k][win(k)][b])
                            shadow[k][addr[k][win(k)]][8*b +: 8] <= wd[k][win(k)][8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt0_k%0d", k), {31'd0, gnt[k][0]}, {31'd0, win(k) == 0});
            chk($sformatf("gnt1_k%0d", k), {31'd0, gnt[k][1]}, {31'd0, win(k) == 1});
            chk($sformatf("ram_we_k%0d", k), {28'd0, rwe[k]},
                {28'd0, win(k) == 1 ? we[k][1] : win(k) == 0 ? we[k][0] : 4'd0});
            chk($sformatf("ram_addr_k%0d", k), {18'd0, raddr[k]},
                {18'd0, win(k) == 1 ? addr[k][1] : win(k) == 0 ? addr[k][0] : 14'd0});
            chk($sformatf("ram_data_k%0d", k), rdata[k],
                win(k) == 1 ? wd[k][1] : win(k) == 0 ? wd[k][0] : 32'd0);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rvalid%0d_k%0d", p, k), {31'd0, rv[k][p]},
                    {31'd0, m_pend[k] && rst_n && (m_tag[k] == (p == 1))});
                chk($sformatf("q%0d_k%0d", p, k), q[k][p],
                    (m_pend[k] && rst_n && (m_tag[k] == (p == 1))) ? m_exp[k] : 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                req[k][p] = 1'b0; we[k][p] = 4'd0; addr[k][p] = 14'd0; wd[k][p] = 32'd0;
            end
    endtask

    task automatic put(input int k, input int p, input logic [3:0] w, input logic [13:0] a,
                       input logic [31:0] d);
        req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wd[k][p] = d;
    endtask

    logic [31:0] lit[3];

    initial begin
        rst_n = 1'b0;
        clr();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1; m_pend[k] = 1'b0; m_tag[k] = 1'b0; m_exp[k] = 32'd0;
            m_gl[k][0] = 1'b0; m_gl[k][1] = 1'b0; rq[k] = 32'd0;
            for (int i = 0; i < 16384; i++) begin
                ram_mem[k][i] = $urandom;
                shadow[k][i] = ram_mem[k][i];
            end
        end
        lit[0] = 32'h33333333; lit[1] = 32'h44444444; lit[2] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            ram_mem[0][3+i] = lit[i]; shadow[0][3+i] = lit[i];
        end
        ram_mem[0][9] = 32'h11223344; shadow[0][9] = 32'h11223344;
        step();
        @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt[0][0]}, 32'd0);
        chk("rst_rvalid0", {31'd0, rv[0][0]}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        // single read
        put(0, 0, 4'd0, 14'd5, 32'd0);
        @(negedge clk);
        chk("t1_gnt0", {31'd0, gnt[0][0]}, 32'd1);
        step();
        clr();
        @(negedge clk);
        chk("t1_rvalid0", {31'd0, rv[0][0]}, 32'd1);
        chk("t1_q0", q[0][0], 32'hDEADBEEF);
        chk("t1_rvalid1", {31'd0, rv[0][1]}, 32'd0);
        // byte write then read back
        step();
        put(0, 1, 4'b0010, 14'd9, 32'h0000AB00);
        @(negedge clk);
        chk("t2_gnt1", {31'd0, gnt[0][1]}, 32'd1);
        chk("t2_ram_we", {28'd0, rwe[0]}, 32'h2);
        step();
        clr();
        put(0, 0, 4'd0, 14'd9, 32'd0);
        @(negedge clk);
        chk("t2_wresp_valid", {31'd0, rv[0][1]}, 32'd1);
        chk("t2_wresp_q", q[0][1], 32'h11223344);
        step();
        clr();
        @(negedge clk);
        chk("t2_read_q", q[0][0], 32'h1122AB44);
        // reset right after a grant
        step();
        put(0, 1, 4'd0, 14'd2, 32'd0);
        @(negedge clk);
        chk("t6_gnt1", {31'd0, gnt[0][1]}, 32'd1);
        step();
        clr();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rvalid1_a", {31'd0, rv[0][1]}, 32'd0);
        step();
        @(negedge clk);
        chk("t6_rvalid1_b", {31'd0, rv[0][1]}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rvalid1_c", {31'd0, rv[0][1]}, 32'd0);
        // continuous contention, round-robin
        step();
        put(0, 0, 4'd0, 14'd1, 32'd0);
        put(0, 1, 4'd0, 14'd2, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt0_%0d", i), {31'd0, gnt[0][0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_gnt1_%0d", i), {31'd0, gnt[0][1]}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        clr();
        @(negedge clk);
        chk("rr_last_rvalid1", {31'd0, rv[0][1]}, 32'd1);
        // idle then back-to-back reads
        step();
        @(negedge clk);
        chk("idle_ram_we", {28'd0, rwe[0]}, 32'd0);
        chk("idle_ram_addr", {18'd0, raddr[0]}, 32'd0);
        chk("idle_rvalid0", {31'd0, rv[0][0]}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            step();
            clr();
            if (j < 3) put(0, 0, 4'd0, 14'(3 + j), 32'd0);
            @(negedge clk);
            if (j > 0) chk($sformatf("b2b_q_%0d", j), q[0][0], lit[j-1]);
        end
        // fixed priority
        step();
        put(1, 0, 4'd0, 14'd1, 32'd0);
        put(1, 1, 4'd0, 14'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fp_gnt0_%0d", i), {31'd0, gnt[1][0]}, 32'd1);
            chk($sformatf("fp_gnt1_%0d", i), {31'd0, gnt[1][1]}, 32'd0);
            step();
        end
        req[1][0] = 1'b0;
        @(negedge clk);
        chk("fp_p1_after_drop", {31'd0, gnt[1][1]}, 32'd1);
        step();
        clr();
        // random traffic with a reset pulse in the middle
        for (int n = 0; n < 600; n++) begin
            step();
            if (n == 300) rst_n = 1'b0;
            if (n == 302) rst_n = 1'b1;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++)
                    if (!req[k][p] || m_gl[k][p]) begin
                        req[k][p] = ($urandom % 4) != 0;
                        addr[k][p] = ($urandom % 8 == 0) ? 14'h3FFF : 14'($urandom % 16);
                        we[k][p] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
                        wd[k][p] = $urandom;
                    end
        end
        step();
        clr();
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
